// File: rtl/spu_recip_scale_if.sv
// rtl/spu_recip_scale_if.sv - reciprocal strobe, element stream and scaled output stream bundle
interface spu_recip_scale_if #(
    parameter int RECIP_DW = 15,
    parameter int ELEM_DW  = 16,
    parameter int OUT_DW   = 16
) ();
    logic [RECIP_DW-1:0] recip_data;
    logic                recip_vld;
    logic [ELEM_DW-1:0]  elem_data;
    logic                elem_vld;
    logic                elem_rdy;
    logic [OUT_DW-1:0]   out_data;
    logic                out_vld;
    logic                out_rdy;
    logic                out_last;

    modport master (
        output recip_data, recip_vld, elem_data, elem_vld, out_rdy,
        input  elem_rdy, out_data, out_vld, out_last
    );

    modport slave (
        input  recip_data, recip_vld, elem_data, elem_vld, out_rdy,
        output elem_rdy, out_data, out_vld, out_last
    );
endinterface

// File: rtl/spu_recip_scale.sv
// rtl/spu_recip_scale.sv - reciprocal FIFO plus per-vector element scaling with round/saturate
// Optional round-half-up before the fractional shift: define SPU_RECIP_ROUND_EN.
module spu_recip_scale #(
    parameter int RECIP_DW   = 15,
    parameter int FRAC_DW    = 14,
    parameter int ELEM_DW    = 16,
    parameter int OUT_DW     = 16,
    parameter int VEC_LEN    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          core_clk,
    input  logic                          rst_n,
    spu_recip_scale_if.slave              bus,
    output logic                          ovf_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PW = ELEM_DW + RECIP_DW;

    localparam logic signed [PW:0] SAT_MAX = {{(PW - OUT_DW + 2){1'b0}}, {(OUT_DW - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW - OUT_DW + 2){1'b1}}, {(OUT_DW - 1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [RECIP_DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q, cnt_d;
    logic [CW-1:0]       elem_cnt_q, elem_cnt_d;
    logic                ovf_q;
    logic                out_vld_q, out_last_q;
    logic [OUT_DW-1:0]   out_data_q;

    logic full, push, pop, accept, last_elem, elem_rdy;
    logic [RECIP_DW-1:0] head;

    assign head      = mem_q[rd_ptr_q];
    assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign elem_rdy  = (state_q == S_RUN) & (~out_vld_q | bus.out_rdy);
    assign accept    = bus.elem_vld & elem_rdy;
    assign last_elem = (elem_cnt_q == CW'(VEC_LEN - 1));
    assign pop       = accept & last_elem;
    // The divider cannot be stalled, so a full FIFO only takes a value if the head leaves this cycle.
    assign push      = bus.recip_vld & (~full | pop);
    assign cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        elem_cnt_d = elem_cnt_q;
        if (accept) begin
            elem_cnt_d = last_elem ? '0 : elem_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cnt_d != '0) state_d = S_RUN;
            S_RUN:   if (pop && (cnt_d == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic signed [PW-1:0] prod;
    logic signed [PW:0]   prod_rnd, shifted;
    logic [OUT_DW-1:0]    sat;

    assign prod = $signed({{RECIP_DW{bus.elem_data[ELEM_DW-1]}}, bus.elem_data})
                * $signed({{ELEM_DW{head[RECIP_DW-1]}}, head});

`ifdef SPU_RECIP_ROUND_EN
    localparam logic signed [PW:0] RND = {{(PW + 1 - FRAC_DW){1'b0}}, 1'b1, {(FRAC_DW - 1){1'b0}}};
    assign prod_rnd = {prod[PW-1], prod} + RND;
`else
    assign prod_rnd = {prod[PW-1], prod};
`endif

    assign shifted = prod_rnd >>> FRAC_DW;

    always_comb begin
        sat = shifted[OUT_DW-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[OUT_DW-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[OUT_DW-1:0];
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.recip_data;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            elem_cnt_q <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            elem_cnt_q <= elem_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.recip_vld && !push) begin
                ovf_q <= 1'b1;
            end
            if (accept) begin
                out_vld_q  <= 1'b1;
                out_data_q <= sat;
                out_last_q <= last_elem;
            end else if (bus.out_rdy) begin
                out_vld_q  <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

    assign bus.elem_rdy = elem_rdy;
    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_last = out_last_q;
    assign ovf_err_o    = ovf_q;
    assign fifo_cnt_o   = cnt_q;
endmodule

// File: doc/spu_recip_scale.md
# spu_recip_scale

Downstream consumer of the signed fixed-point divider in the SPU normalisation path. Captures each quotient (a per-vector reciprocal) from the divider's fire-and-forget `div_ack` pulse into a small FIFO. Multiplies a following stream of `VEC_LEN` signed elements by that reciprocal, then rounds, saturates and emits the result on a valid/ready interface. Absorbs the divider's lack of backpressure and decouples reciprocal arrival from element streaming.

## Interface
Parameters:
- `RECIP_DW`, 15 — quotient width; signed Q(RECIP_DW-FRAC_DW).FRAC_DW.
- `FRAC_DW`, 14 — fractional bits of the reciprocal.
- `ELEM_DW`, 16 — signed integer element width.
- `OUT_DW`, 16 — signed output width.
- `VEC_LEN`, 64 — elements per reciprocal; must be ≥1.
- `FIFO_DEPTH`, 4 — reciprocal FIFO entries; must be a power of 2 and ≥2.

Ports:
- `core_clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `recip_data` in RECIP_DW — quotient from the divider (`div_data_out`).
- `recip_vld` in 1 — single-cycle strobe from the divider (`div_ack`); no ready is returned.
- `elem_data` in ELEM_DW — element to scale.
- `elem_vld` in 1 — element valid.
- `elem_rdy` out 1 — element accepted when `elem_vld & elem_rdy`.
- `out_data` out OUT_DW — scaled, saturated result.
- `out_vld` out 1 — output valid.
- `out_rdy` in 1 — downstream ready.
- `out_last` out 1 — marks the last element of the vector; qualified by `out_vld`.
- `ovf_err` out 1 — sticky flag: a reciprocal was dropped.
- `fifo_cnt` out clog2(FIFO_DEPTH)+1 — number of FIFO entries occupied.

## Operation
- **FIFO push:** `recip_data` is written on `recip_vld`.
  - If the FIFO is full and no pop occurs in the same cycle, the value is dropped and `ovf_err` is set.
  - `ovf_err` clears only on reset.
  - A push while full with a same-cycle pop is accepted.
- **Accept condition:** `elem_rdy = fifo_not_empty & (~out_vld | out_rdy)`. This is combinational; no dependency on `elem_vld`.
- **Arithmetic, on accept:**
  - `prod = $signed(elem_data) * $signed(fifo_head)`, full width ELEM_DW+RECIP_DW.
  - `prod` is arithmetic-shifted right by FRAC_DW after the optional rounding add (see Configuration).
  - The result saturates to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1].
- **Element counter:** `elem_cnt` (0..VEC_LEN-1) increments on each accept.
  - On the accept where `elem_cnt == VEC_LEN-1`: `out_last` is registered high, the FIFO head is popped, and `elem_cnt` wraps to 0.
- **Two-state control:**
  - IDLE (FIFO empty, `elem_rdy` = 0) → RUN when `fifo_cnt` ≥ 1.
  - RUN → IDLE after the last-element pop leaves the FIFO empty.
  - A push and the last-element pop in the same cycle keep the state at RUN.
- **Output register:** holds `out_data`/`out_last` until `out_vld & out_rdy`. `out_vld` drops after the handshake unless a new element is accepted in the same cycle.

## Timing
- Reset values: `elem_rdy` 0, `out_data` 0, `out_vld` 0, `out_last` 0, `ovf_err` 0, `fifo_cnt` 0. FIFO pointers and `elem_cnt` are 0.
- Push latency: a reciprocal arriving at cycle N is usable at N+1 (`fifo_cnt` updates at N+1; `elem_rdy` can assert at N+1).
- Data latency: an element accepted at cycle N produces `out_vld` at N+1.
- Throughput: one element per cycle with `out_rdy` held high.
- Backpressure: `out_rdy` low with `out_vld` high holds `elem_rdy` low; no element is lost.
- Asserting `rst_n` low mid-vector discards the partial vector, the FIFO contents and the output register immediately.

## Configuration
- `SPU_RECIP_ROUND_EN` defined: before the shift, add `1 << (FRAC_DW-1)` to `prod` (round-half-up toward +inf).
- Undefined: no add; the plain arithmetic shift gives floor (truncation toward -inf).
- Saturation is identical in both builds.

## Test plan
- **Basic scaling:** push recip 0x1000 (0.25); stream 64 elements of value 100 with `out_rdy`=1 → 64 outputs of 25, one per cycle; `out_last` only on the 64th; `fifo_cnt` goes 1→0 after the 64th accept.
- **Rounding:** recip 0x1000, elem 3 (exact 0.75) → 1 with `SPU_RECIP_ROUND_EN`, 0 without. Recip -8192 (-0.5), elem 7 (exact -3.5) → -3 with the macro, -4 without.
- **Saturation:** recip -16384 (-1.0), elem -32768 → 32767. Elem 32767 → -32767.
- **Overflow:** with no elements sent, push 5 reciprocals (FIFO_DEPTH=4) → `fifo_cnt`=4, `ovf_err`=1, and the 5th value is absent from the outputs. A push coincident with a last-element pop while full → accepted, `ovf_err` stays 0.
- **Backpressure:** toggle `out_rdy` randomly over 2 vectors → output sequence identical to the free-running case; `elem_rdy` low whenever `out_vld & ~out_rdy`.
- **Reset mid-operation:** assert `rst_n` low after 10 elements of a vector → all outputs return to reset values at once. Push a new reciprocal → the next vector starts at `elem_cnt`=0, and `out_last` lands on its 64th element.
